// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding,
// default memory size and the address legality check.
package dmem_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    RESP  = S_RESP
  } state_t;

  localparam logic [31:0] MEM_BYTES_DEF = 32'h0000_0080;

  // An access is illegal when it falls past the end of dataMem or is not word aligned.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] limit);
    return (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's request/response channel into the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the port that did not win last
// time is granted; last_grant only moves when the caller commits a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_grant;

  // Grant decode: a lone requester always wins, a tie goes away from last_grant.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the committed winner; reset value favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (upd)
      last_grant <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dataMem between the CPU MEM stage (port 0) and the
// debug/loader port (port 1). Each access runs IDLE -> ISSUE -> RESP.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_storeW,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_out
);

  state_t            state, state_nxt;
  logic [1:0]        req, gnt;
  logic              accept;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              port_p0;
  logic              err_p0;
  logic [DATA_W-1:0] rdata_p1;

  assign req    = {p1.req_valid, p0.req_valid};
  assign accept = (state == IDLE) && (req != 2'b00);

  rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .req (req),
    .upd (accept),
    .gnt (gnt)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- stage p0: capture the granted request at the accept edge ----
  // Datapath capture; later changes on the request inputs are ignored.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_p0    <= gnt[1] ? p1.req_we    : p0.req_we;
      addr_p0  <= gnt[1] ? p1.req_addr  : p0.req_addr;
      wdata_p0 <= gnt[1] ? p1.req_wdata : p0.req_wdata;
      port_p0  <= gnt[1];
      err_p0   <= addr_err(32'(gnt[1] ? p1.req_addr : p0.req_addr), MEM_BYTES);
    end
  end

  // ---- stage p1: register the memory read at the ISSUE -> RESP edge ----
  // Stores and illegal accesses return zero data.
  always_ff @(posedge CLK) begin
    if (state == ISSUE)
      rdata_p1 <= (we_p0 || err_p0) ? '0 : mem_out;
  end

  // Next state plus every output; all outputs idle at zero outside their state.
  always_comb begin
    state_nxt    = state;
    p0.req_ready = 1'b0;
    p1.req_ready = 1'b0;
    p0.rsp_valid = 1'b0;
    p0.rsp_rdata = '0;
    p0.rsp_err   = 1'b0;
    p1.rsp_valid = 1'b0;
    p1.rsp_rdata = '0;
    p1.rsp_err   = 1'b0;
    mem_addr     = '0;
    mem_storeW   = '0;
    mem_store    = 1'b0;
    case (state)
      IDLE: begin
        p0.req_ready = gnt[0];
        p1.req_ready = gnt[1];
        if (accept)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_addr   = addr_p0;
        mem_storeW = wdata_p0;
        // Reset in this cycle must not let the write land.
        mem_store  = we_p0 && !err_p0 && !RST;
        state_nxt  = RESP;
      end
      RESP: begin
        if (port_p0) begin
          p1.rsp_valid = 1'b1;
          p1.rsp_rdata = rdata_p1;
          p1.rsp_err   = err_p0;
        end else begin
          p0.rsp_valid = 1'b1;
          p0.rsp_rdata = rdata_p1;
          p0.rsp_err   = err_p0;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: dataMem model behind the arbiter, two requester channels.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] mem_addr, mem_storeW, mem_out;
  logic        mem_store;
  logic [31:0] mem [0:31];

  int vectors     = 0;
  int miscompares = 0;
  int st_cnt = 0, r0_cnt = 0, r1_cnt = 0;
  int s_save, r0_save, r1_save;

  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p0_if ();
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p1_if ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(32'h80)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .p0         (p0_if),
    .p1         (p1_if),
    .mem_addr   (mem_addr),
    .mem_storeW (mem_storeW),
    .mem_store  (mem_store),
    .mem_out    (mem_out)
  );

  // dataMem: combinational read, write on the clock edge.
  assign mem_out = mem[mem_addr[6:2]];
  always @(posedge CLK) if (mem_store) mem[mem_addr[6:2]] <= mem_storeW;

  // Event counters for stores and responses.
  always @(posedge CLK) begin
    if (mem_store)       st_cnt <= st_cnt + 1;
    if (p0_if.rsp_valid) r0_cnt <= r0_cnt + 1;
    if (p1_if.rsp_valid) r1_cnt <= r1_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int port, input logic v, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = a; p0_if.req_wdata = d;
    end else begin
      p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = a; p1_if.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? p0_if.req_ready : p1_if.req_ready;
  endfunction
  function automatic logic rv(input int port);
    return (port == 0) ? p0_if.rsp_valid : p1_if.rsp_valid;
  endfunction
  function automatic logic [31:0] rd(input int port);
    return (port == 0) ? p0_if.rsp_rdata : p1_if.rsp_rdata;
  endfunction
  function automatic logic re(input int port);
    return (port == 0) ? p0_if.rsp_err : p1_if.rsp_err;
  endfunction

  // One complete single-requester transaction, starting and ending at an IDLE negedge.
  task automatic xact(input int port, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err, input logic exp_store);
    drv(port, 1'b1, we, a, d);
    #1 chk("idle_ready", 32'(rdy(port)), 32'd1);
    @(negedge CLK);
    drv(port, 1'b0, we, a, d);
    #1;
    chk("issue_ready", 32'(rdy(port)), 32'd0);
    chk("issue_addr", mem_addr, a);
    chk("issue_store", 32'(mem_store), 32'(exp_store));
    chk("issue_rsp", 32'(rv(port)), 32'd0);
    @(negedge CLK);
    chk("resp_valid", 32'(rv(port)), 32'd1);
    chk("resp_other", 32'(rv(1 - port)), 32'd0);
    chk("resp_rdata", rd(port), exp_rd);
    chk("resp_err", 32'(re(port)), 32'(exp_err));
    @(negedge CLK);
    chk("post_valid", 32'(rv(port)), 32'd0);
    chk("post_addr", mem_addr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    RST = 1'b1;
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst_rsp0", 32'(p0_if.rsp_valid), 32'd0);
    chk("rst_rsp1", 32'(p1_if.rsp_valid), 32'd0);
    chk("rst_rdata0", p0_if.rsp_rdata, 32'd0);
    chk("rst_err1", 32'(p1_if.rsp_err), 32'd0);
    chk("rst_store", 32'(mem_store), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_storeW", mem_storeW, 32'd0);
    RST = 1'b0;

    // 1: store then load at 0x10 on port 0
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    chk("t1_mem", mem[4], 32'hDEAD_BEEF);
    xact(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // 2: both ports valid every cycle, alternate from port 0 after reset
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    r0_save = r0_cnt; r1_save = r1_cnt;
    drv(0, 1'b1, 1'b0, 32'h00, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h04, 32'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t2_rdy0", 32'(p0_if.req_ready), 32'd1);
      chk("t2_rdy1", 32'(p1_if.req_ready), 32'd0);
      @(negedge CLK);
      chk("t2_addr0", mem_addr, 32'h00);
      @(negedge CLK);
      chk("t2_rsp0", 32'(p0_if.rsp_valid), 32'd1);
      chk("t2_rsp1_quiet", 32'(p1_if.rsp_valid), 32'd0);
      chk("t2_rdata0", p0_if.rsp_rdata, 32'h1000_0000);
      @(negedge CLK);
      chk("t2_rdy1b", 32'(p1_if.req_ready), 32'd1);
      chk("t2_rdy0b", 32'(p0_if.req_ready), 32'd0);
      @(negedge CLK);
      chk("t2_addr1", mem_addr, 32'h04);
      @(negedge CLK);
      chk("t2_rsp1", 32'(p1_if.rsp_valid), 32'd1);
      chk("t2_rsp0_quiet", 32'(p0_if.rsp_valid), 32'd0);
      chk("t2_rdata1", p1_if.rsp_rdata, 32'h1000_0001);
      @(negedge CLK);
    end
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t2_cnt0", 32'(r0_cnt - r0_save), 32'd2);
    chk("t2_cnt1", 32'(r1_cnt - r1_save), 32'd2);

    // 3: port 1 out-of-range load and misaligned store
    s_save = st_cnt;
    xact(1, 1'b0, 32'h80, 32'd0, 32'd0, 1'b1, 1'b0);
    xact(1, 1'b1, 32'h06, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
    chk("t3_nostore", 32'(st_cnt - s_save), 32'd0);
    chk("t3_mem", mem[1], 32'h1000_0001);

    // 4: reset during the ISSUE cycle of a store to 0x20
    s_save = st_cnt; r0_save = r0_cnt;
    drv(0, 1'b1, 1'b1, 32'h20, 32'h55AA_55AA);
    #1 chk("t4_rdy", 32'(p0_if.req_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t4_store_gated", 32'(mem_store), 32'd0);
    chk("t4_issue_addr", mem_addr, 32'h20);
    @(negedge CLK);
    RST = 1'b0;
    chk("t4_norsp_a", 32'(p0_if.rsp_valid), 32'd0);
    @(negedge CLK);
    chk("t4_norsp_b", 32'(r0_cnt - r0_save), 32'd0);
    chk("t4_nostore", 32'(st_cnt - s_save), 32'd0);
    chk("t4_mem", mem[8], 32'h1000_0008);
    drv(0, 1'b1, 1'b0, 32'h20, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h04, 32'd0);
    #1;
    chk("t4_prio0", 32'(p0_if.req_ready), 32'd1);
    chk("t4_prio1", 32'(p1_if.req_ready), 32'd0);
    @(negedge CLK);
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 chk("t4_addr", mem_addr, 32'h20);
    @(negedge CLK);
    chk("t4_rsp0", 32'(p0_if.rsp_valid), 32'd1);
    chk("t4_rdata", p0_if.rsp_rdata, 32'h1000_0008);
    @(negedge CLK);

    // 5: valid held while busy, wdata changed after accept
    drv(0, 1'b1, 1'b1, 32'h30, 32'h1111_1111);
    #1 chk("t5_rdy_idle", 32'(p0_if.req_ready), 32'd1);
    @(negedge CLK);
    p0_if.req_wdata = 32'h2222_2222;
    #1;
    chk("t5_rdy_issue", 32'(p0_if.req_ready), 32'd0);
    chk("t5_storeW", mem_storeW, 32'h1111_1111);
    @(negedge CLK);
    chk("t5_rdy_resp", 32'(p0_if.req_ready), 32'd0);
    chk("t5_rsp", 32'(p0_if.rsp_valid), 32'd1);
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    chk("t5_mem", mem[12], 32'h1111_1111);
    chk("t5_idle_addr", mem_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
